// File: rtl/bus_pkg.sv
// Shared constants and types for the four-source bus arbiter.
package bus_pkg;

  localparam int unsigned N_SRC = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first candidate at or after ptr+1, wrapping, skipping excluded sources.
module rr_pick
  import bus_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [1:0]       ptr,
  input  logic [N_SRC-1:0] excl,
  output logic             found,
  output logic [1:0]       idx
);

  logic [N_SRC-1:0] cand;
  logic [1:0]       pos;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    pos   = '0;
    cand  = req & ~excl;
    // i == N_SRC wraps back to ptr itself, so it is searched last
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      pos = ptr + 2'(i);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with capped tenure; drives bus select lines and a one-hot grant.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [1:0] owner
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] sel_q, sel_d;

  logic [3:0] excl;
  logic       found;
  logic [1:0] pick_idx;
  logic       take;

  // The current owner never competes against itself while it holds the bus
  assign excl = (state_q == ST_OWN) ? onehot(owner_q) : '0;

  rr_pick u_pick (
    .req   (req),
    .ptr   (owner_q),
    .excl  (excl),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    take    = 1'b0;

    unique case (state_q)
      ST_IDLE: take = found;
      ST_OWN: begin
        if (!req[owner_q]) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q < MaxHold) begin
          cnt_d = cnt_q + 4'd1;
        end else if (found) begin
          take = 1'b1;
        end else begin
          cnt_d = 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      state_d = ST_OWN;
      gnt_d   = onehot(pick_idx);
      owner_d = pick_idx;
      sel_d   = pick_idx;
      cnt_d   = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      owner_q <= SRC_D;
      sel_q   <= SRC_A;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign busy  = (state_q == ST_OWN);
  assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed vectors plus a random invariant/fairness phase.
module tb_bus_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam int          WAIT_MAX = 3 * MAX_HOLD + 1;

  logic       clk;
  logic       clr;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [1:0] owner;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .clr   (clr),
    .req   (req),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy),
    .owner (owner)
  );

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] owner;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         rnd = 1'b0;
  bit         have_prev = 1'b0;
  int         waitc[4];
  logic [3:0] prev_gnt;
  logic [3:0] prev_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
  endfunction

  // Monitor: pops expectations due this cycle; in the random phase checks invariants
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check({e.name, "_stale"}, 32'(cyc), 32'(e.cyc));
      end else begin
        check({e.name, "_gnt"}, 32'(gnt), 32'(e.gnt));
        check({e.name, "_sel"}, 32'({s1, s0}), 32'(e.sel));
        check({e.name, "_busy"}, 32'(busy), 32'(e.busy));
        check({e.name, "_owner"}, 32'(owner), 32'(e.owner));
      end
    end
    if (rnd) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("busy_vs_gnt", 32'(busy), 32'(|gnt));
      if (busy) check("sel_vs_owner", 32'({s1, s0}), 32'(owner));
      for (int i = 0; i < 4; i++) begin
        if (have_prev && prev_gnt[i] && !prev_req[i]) check("release", 32'(gnt[i]), 32'd0);
        if (req[i] && !gnt[i]) begin
          waitc[i]++;
          check("max_wait", 32'(waitc[i] <= WAIT_MAX), 32'd1);
        end else begin
          waitc[i] = 0;
        end
      end
      prev_gnt  = gnt;
      prev_req  = req;
      have_prev = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) waitc[i] = 0;
      have_prev = 1'b0;
    end
  end

  // Drive one cycle of inputs and queue the response expected after the next edge
  task automatic apply(input logic c, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] es, input logic eb, input logic [1:0] eo,
                       input string nm);
    @(posedge clk);
    #1;
    clr = c;
    req = r;
    sb.push_back('{cyc: cyc + 1, gnt: eg, sel: es, busy: eb, owner: eo, name: nm});
  endtask

  initial begin
    logic [1:0] k;
    logic [3:0] nr;
    clr = 1'b1;
    req = 4'b0000;

    apply(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd3, "reset");
    apply(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 2'd0, "grant_a");
    apply(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "release_a");

    // Full contention: each source holds exactly MAX_HOLD cycles
    apply(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd3, "rst_before_rot");
    for (int i = 0; i < 17; i++) begin
      k = 2'((i / 4) % 4);
      apply(1'b0, 4'b1111, 4'b0001 << k, k, 1'b1, k, "rotate");
    end

    for (int i = 0; i < 20; i++) apply(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2, "hold_c");

    apply(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 2'd1, "to_b");
    apply(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3, "handover_d");
    apply(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'd3, "idle_sel_held");

    apply(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2, "grant_c");
    apply(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd3, "clr_mid");
    apply(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 2'd0, "restart_a");

    // After reset only d requests: pointer at 3 must still allow d to win
    apply(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd3, "reset2");
    apply(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3, "first_d");
    for (int i = 0; i < 6; i++) apply(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3, "reload_d");
    apply(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'd3, "final_idle");

    @(posedge clk);
    @(posedge clk);
    #1;
    rnd = 1'b1;
    repeat (2000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        nr[i] = req[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      end
      req = nr;
    end
    @(posedge clk);
    #1;
    rnd = 1'b0;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
